// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache between MEM stage and SRAM controller.
// Optional macro CACHE_WRITE_UPDATE_EN: write hits update the cached word in place instead of invalidating the line.
module cache_controller #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int          INDEX_W   = 6,
  parameter int          TAG_W     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        sram_read_en,
  output logic        sram_write_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [63:0] sram_read_data,
  input  logic        sram_ready
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_L = INDEX_W + 3;
  localparam int TAG_H = INDEX_W + TAG_W + 2;

  typedef enum logic [1:0] {IDLE, RMISS, WRITE} state_t;

  state_t state, state_next;

  logic [31:0]        da;
  logic               word_sel;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               unused_da;

  logic [SETS-1:0]    valid_q [2];
  logic [SETS-1:0]    lru_q;
  logic [TAG_W-1:0]   tag_mem  [2][SETS];
  logic [63:0]        data_mem [2][SETS];

  logic               hit0, hit1, hit, hit_way, lru_way;
  logic [63:0]        hit_line;
  logic               rd_hit, wr_hit, fill;

  function automatic logic [31:0] pick_word(input logic [63:0] line, input logic sel);
    return sel ? line[63:32] : line[31:0];
  endfunction

  assign da        = address - BASE_ADDR;
  assign word_sel  = da[2];
  assign idx       = da[TAG_L-1:3];
  assign tag       = da[TAG_H:TAG_L];
  assign unused_da = ^{da[31:TAG_H+1], da[1:0]};

  assign sram_address    = address;
  assign sram_write_data = write_data;

  // A double hit cannot arise from normal fills; way 0 wins if it ever does.
  assign hit0     = valid_q[0][idx] && (tag_mem[0][idx] == tag);
  assign hit1     = valid_q[1][idx] && (tag_mem[1][idx] == tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = ~hit0;
  assign hit_line = data_mem[hit_way][idx];
  assign lru_way  = lru_q[idx];

  // Outputs are forced to their idle values while reset is held so an abandoned miss drops at once.
  always_comb begin
    state_next    = state;
    ready         = 1'b1;
    read_data     = '0;
    sram_read_en  = 1'b0;
    sram_write_en = 1'b0;
    rd_hit        = 1'b0;
    wr_hit        = 1'b0;
    fill          = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (read_en) begin
            if (hit) begin
              read_data = pick_word(hit_line, word_sel);
              rd_hit    = 1'b1;
            end else begin
              ready        = 1'b0;
              sram_read_en = 1'b1;
              state_next   = RMISS;
            end
          end else if (write_en) begin
            ready         = 1'b0;
            sram_write_en = 1'b1;
            wr_hit        = hit;
            state_next    = WRITE;
          end
        end
        RMISS: begin
          sram_read_en = 1'b1;
          ready        = sram_ready;
          if (sram_ready) begin
            read_data  = pick_word(sram_read_data, word_sel);
            fill       = 1'b1;
            state_next = IDLE;
          end
        end
        WRITE: begin
          sram_write_en = 1'b1;
          ready         = sram_ready;
          if (sram_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else begin
      state <= state_next;
      if (rd_hit) lru_q[idx] <= ~hit_way;
      if (wr_hit) begin
`ifdef CACHE_WRITE_UPDATE_EN
        lru_q[idx] <= ~hit_way;
`else
        valid_q[hit_way][idx] <= 1'b0;
        lru_q[idx]            <= hit_way;
`endif
      end
      if (fill) begin
        valid_q[lru_way][idx] <= 1'b1;
        lru_q[idx]            <= ~lru_way;
      end
    end
  end

  // Tag and data storage carry no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[lru_way][idx]  <= tag;
      data_mem[lru_way][idx] <= sram_read_data;
    end
`ifdef CACHE_WRITE_UPDATE_EN
    if (wr_hit) begin
      if (word_sel) data_mem[hit_way][idx][63:32] <= write_data;
      else          data_mem[hit_way][idx][31:0]  <= write_data;
    end
`endif
  end

endmodule

// File: tb/tb_cache_controller.sv
// Randomized self-checking bench for cache_controller against a set/way/LRU reference model and an SRAM word store.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_en, write_en;
  logic [31:0] address, write_data, read_data;
  logic        ready, sram_read_en, sram_write_en;
  logic [31:0] sram_address, sram_write_data;
  logic [63:0] sram_read_data;
  logic        sram_ready;

  int n_vec = 0;
  int n_err = 0;

  localparam int SETS = 64;
  bit          m_valid [2][SETS];
  logic [9:0]  m_tag   [2][SETS];
  bit          m_lru   [SETS];
  logic [31:0] mem [logic [31:0]];

  cache_controller dut (
    .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en),
    .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
    .sram_address(sram_address), .sram_write_data(sram_write_data),
    .sram_read_data(sram_read_data), .sram_ready(sram_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int set_of(input logic [31:0] a);
    logic [31:0] d;
    d = a - 32'd1024;
    return int'(d[8:3]);
  endfunction

  function automatic logic [9:0] tag_of(input logic [31:0] a);
    logic [31:0] d;
    d = a - 32'd1024;
    return d[18:9];
  endfunction

  function automatic int find_way(input logic [31:0] a);
    for (int w = 0; w < 2; w++)
      if (m_valid[w][set_of(a)] && m_tag[w][set_of(a)] == tag_of(a)) return w;
    return -1;
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    logic [31:0] k;
    k = a & ~32'd3;
    if (!mem.exists(k)) mem[k] = $urandom;
    return mem[k];
  endfunction

  function automatic logic [63:0] line_of(input logic [31:0] a);
    logic [31:0] b;
    b = a & ~32'd7;
    return {word(b + 32'd4), word(b)};
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_valid[0][s] = 1'b0;
      m_valid[1][s] = 1'b0;
      m_lru[s]      = 1'b0;
    end
  endfunction

  task automatic idle_cycle();
    read_en = 1'b0; write_en = 1'b0; sram_ready = 1'b0;
    #3;
    chk("idle_ready", ready, 1);
    chk("idle_rd_en", sram_read_en, 0);
    chk("idle_wr_en", sram_write_en, 0);
    chk("idle_data", read_data, 0);
    @(posedge clk); #1;
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input int lat);
    int s, w, v;
    logic [31:0] exp_w;
    s = set_of(a);
    w = find_way(a);
    read_en = rd; write_en = wr; address = a; write_data = wd;
    sram_ready = 1'b0; sram_read_data = line_of(a);
    exp_w = word(a);
    #3;
    chk("addr_pass", sram_address, a);
    if (rd && w >= 0) begin
      chk("hit_ready", ready, 1);
      chk("hit_data", read_data, exp_w);
      chk("hit_sram_rd", sram_read_en, 0);
      chk("hit_sram_wr", sram_write_en, 0);
      m_lru[s] = (w == 0);
    end else begin
      chk("req_ready", ready, 0);
      chk("req_rd_en", sram_read_en, rd);
      chk("req_wr_en", sram_write_en, !rd);
      chk("req_data", read_data, 0);
      if (!rd) chk("wr_data", sram_write_data, wd);
      for (int c = 1; c <= lat; c++) begin
        @(posedge clk); #1;
        sram_ready = (c == lat);
        #3;
        chk("wait_ready", ready, c == lat);
        chk("wait_rd_en", sram_read_en, rd);
        chk("wait_wr_en", sram_write_en, !rd);
        chk("wait_data", read_data, (rd && c == lat) ? exp_w : 32'd0);
      end
      if (rd) begin
        v = m_lru[s];
        m_valid[v][s] = 1'b1;
        m_tag[v][s]   = tag_of(a);
        m_lru[s]      = (v == 0);
      end else begin
        mem[a & ~32'd3] = wd;
        if (w >= 0) begin
`ifdef CACHE_WRITE_UPDATE_EN
          m_lru[s] = (w == 0);
`else
          m_valid[w][s] = 1'b0;
          m_lru[s]      = w[0];
`endif
        end
      end
    end
    @(posedge clk); #1;
    read_en = 1'b0; write_en = 1'b0; sram_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int op;
    rst = 1'b1; read_en = 1'b0; write_en = 1'b0; address = '0; write_data = '0;
    sram_read_data = '0; sram_ready = 1'b0;
    model_reset();
    idle_cycle();
    rst = 1'b0;
    idle_cycle();

    mem[32'd1024] = 32'h11111111;
    mem[32'd1028] = 32'h22222222;
    access(1, 0, 32'd1024, 32'd0, 5);
    access(1, 0, 32'd1028, 32'd0, 3);
    access(1, 0, 32'd1536, 32'd0, 2);
    access(1, 0, 32'd1024, 32'd0, 2);
    access(1, 0, 32'd2048, 32'd0, 2);
    access(1, 0, 32'd1024, 32'd0, 2);
    access(1, 0, 32'd1536, 32'd0, 2);
    access(0, 1, 32'd1024, 32'hDEADBEEF, 3);
    idle_cycle();
    access(1, 0, 32'd1024, 32'd0, 2);

    // Reset in the middle of a line fetch.
    read_en = 1'b1; address = 32'd1032; sram_read_data = line_of(32'd1032);
    #3;
    chk("pre_rst_rd_en", sram_read_en, find_way(32'd1032) < 0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_rd_en", sram_read_en, 0);
    chk("rst_ready", ready, 1);
    chk("rst_wr_en", sram_write_en, 0);
    @(posedge clk); #1;
    read_en = 1'b0; rst = 1'b0;
    model_reset();
    access(1, 0, 32'd1032, 32'd0, 2);
    access(1, 0, 32'd1024, 32'd0, 1);

    access(1, 1, 32'd3072, 32'hCAFEF00D, 3);
    access(1, 0, 32'd3072, 32'd0, 1);

    for (int i = 0; i < 300; i++) begin
      a = 32'd1024 + ($urandom_range(0, 3) << 9) + ($urandom_range(0, 3) << 3)
          + ($urandom_range(0, 1) << 2);
      op = $urandom_range(0, 9);
      if (op < 5)       access(1, 0, a, 32'd0, $urandom_range(1, 4));
      else if (op < 8)  access(0, 1, a, $urandom, $urandom_range(1, 4));
      else if (op == 8) access(1, 1, a, $urandom, $urandom_range(1, 4));
      else              idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
